// File: rtl/game_timer_pkg.sv
// Shared state encoding and BCD limits for the game timer.
package game_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  localparam logic [3:0] BCD_NINE    = 4'h9;
  localparam logic [7:0] SEC_LAST    = 8'h59;
  localparam logic [3:0] SEC_HI_LAST = SEC_LAST[7:4];

endpackage

// File: rtl/game_timer_bcd_digit.sv
// One BCD digit counting 0..LAST; steps when enabled and carry-in is high.
module bcd_digit #(
  parameter logic [3:0] LAST = 4'h9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_ci,
  output logic [3:0] o_q,
  output logic       o_co
);

  logic [3:0] r_q;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_q <= 4'h0;
    end else if (i_en && i_ci) begin
      r_q <= (r_q == LAST) ? 4'h0 : r_q + 4'h1;
    end
  end

  assign o_q  = r_q;
  assign o_co = i_ci && (r_q == LAST);

endmodule

// File: rtl/game_timer.sv
// Game elapsed-time counter (MM:SS in BCD) with run/pause/over control.
// Define GAME_TIMER_SATURATE_EN to hold at MIN_LAST:59 instead of rolling over.
module game_timer
  import game_timer_pkg::*;
#(
  parameter logic [7:0] MIN_LAST = 8'h99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [1:0] state,
  output logic       wrap
);

  state_t r_state;
  logic   r_tick_q;
  logic   r_wrap;

  logic       w_edge;
  logic       w_run_evt;
  logic       w_at_end;
  logic       w_wrap_set;
  logic       w_inc;
  logic       w_clr;
  logic [3:0] w_s0, w_s1, w_m0, w_m1;
  logic       w_c0, w_c1, w_c2, w_c3;

  assign w_edge    = sec_tick && !r_tick_q;
  // Only a clean edge in RUN with no competing request advances the count.
  assign w_run_evt = (r_state == ST_RUN) && !start && !stop && !pause && w_edge;
  assign w_at_end  = ({min_bcd, sec_bcd} == {MIN_LAST, SEC_LAST});
  assign w_wrap_set = w_run_evt && w_at_end;

`ifdef GAME_TIMER_SATURATE_EN
  assign w_inc = w_run_evt && !w_at_end;
  assign w_clr = start;
`else
  assign w_inc = w_run_evt;
  assign w_clr = start || w_wrap_set;
`endif

  bcd_digit #(.LAST(BCD_NINE)) u_sec_lo (
    .clk(clk), .reset(reset), .i_clr(w_clr), .i_en(w_inc), .i_ci(1'b1),
    .o_q(w_s0), .o_co(w_c0)
  );
  bcd_digit #(.LAST(SEC_HI_LAST)) u_sec_hi (
    .clk(clk), .reset(reset), .i_clr(w_clr), .i_en(w_inc), .i_ci(w_c0),
    .o_q(w_s1), .o_co(w_c1)
  );
  bcd_digit #(.LAST(BCD_NINE)) u_min_lo (
    .clk(clk), .reset(reset), .i_clr(w_clr), .i_en(w_inc), .i_ci(w_c1),
    .o_q(w_m0), .o_co(w_c2)
  );
  bcd_digit #(.LAST(BCD_NINE)) u_min_hi (
    .clk(clk), .reset(reset), .i_clr(w_clr), .i_en(w_inc), .i_ci(w_c2),
    .o_q(w_m1), .o_co(w_c3)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_wrap   <= 1'b0;
      r_tick_q <= 1'b1;
    end else begin
      r_tick_q <= sec_tick;
      r_wrap   <= w_wrap_set;
      case (r_state)
        ST_IDLE:  if (start) r_state <= ST_RUN;
        ST_RUN: begin
          if (start)      r_state <= ST_RUN;
          else if (stop)  r_state <= ST_OVER;
          else if (pause) r_state <= ST_PAUSE;
        end
        ST_PAUSE: begin
          if (start)      r_state <= ST_RUN;
          else if (stop)  r_state <= ST_OVER;
          else if (pause) r_state <= ST_RUN;
        end
        ST_OVER:  if (start) r_state <= ST_RUN;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign sec_bcd = {w_s1, w_s0};
  assign min_bcd = {w_m1, w_m0};
  assign state   = r_state;
  assign wrap    = r_wrap;

  logic w_unused;
  assign w_unused = w_c3;

endmodule

// File: tb/tb_game_timer.sv
// Directed-vector bench for game_timer with hand-computed expectations.
module tb_game_timer;

  logic       clk = 1'b0;
  logic       reset, sec_tick, start, pause, stop;
  logic [7:0] sec_bcd, min_bcd;
  logic [1:0] state;
  logic       wrap;

  int n_tests = 0;
  int n_fail  = 0;

  game_timer #(.MIN_LAST(8'h99)) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick), .start(start),
    .pause(pause), .stop(stop), .sec_bcd(sec_bcd), .min_bcd(min_bcd),
    .state(state), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      sec_tick = 1'b1; step();
      sec_tick = 1'b0; step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1; step(); pause = 1'b0;
  endtask

  initial begin
    reset = 1'b0; sec_tick = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;

    // Reset state
    do_reset();
    check("rst_state", state, 2'b00);
    check("rst_sec", sec_bcd, 8'h00);
    check("rst_min", min_bcd, 8'h00);
    check("rst_wrap", wrap, 1'b0);

    // IDLE ignores pause and stop
    pulse_pause();
    stop = 1'b1; step(); stop = 1'b0;
    tick(2);
    check("idle_hold_state", state, 2'b00);
    check("idle_hold_sec", sec_bcd, 8'h00);

    pulse_start();
    check("start_state", state, 2'b01);
    check("start_sec", sec_bcd, 8'h00);

    // 61 edges -> 01:01
    tick(61);
    check("t61_min", min_bcd, 8'h01);
    check("t61_sec", sec_bcd, 8'h01);

    // Level held high counts once
    sec_tick = 1'b1;
    repeat (5) step();
    sec_tick = 1'b0; step();
    check("level_sec", sec_bcd, 8'h02);
    check("level_min", min_bcd, 8'h01);

    // start while running restarts at 00:00
    pulse_start();
    check("restart_state", state, 2'b01);
    check("restart_sec", sec_bcd, 8'h00);
    check("restart_min", min_bcd, 8'h00);

    // Level high at reset release is not counted
    sec_tick = 1'b1;
    reset = 1'b1; step(); reset = 1'b0;
    pulse_start();
    repeat (3) step();
    check("rel_high_sec", sec_bcd, 8'h00);
    sec_tick = 1'b0; step();
    tick(1);
    check("rel_high_after", sec_bcd, 8'h01);

    // Pause / resume around 00:09
    do_reset(); pulse_start();
    tick(9);
    check("p_pre", sec_bcd, 8'h09);
    pulse_pause();
    check("p_state", state, 2'b10);
    tick(3);
    check("p_discard", sec_bcd, 8'h09);
    pulse_pause();
    check("p_resume", state, 2'b01);
    tick(1);
    check("p_after", sec_bcd, 8'h10);

    // Pause coinciding with an edge drops the edge
    sec_tick = 1'b1; pause = 1'b1; step();
    sec_tick = 1'b0; pause = 1'b0; step();
    check("pe_state", state, 2'b10);
    check("pe_sec", sec_bcd, 8'h10);
    pulse_pause();

    // Stop with edge at 00:20
    tick(10);
    check("s_pre", sec_bcd, 8'h20);
    sec_tick = 1'b1; stop = 1'b1; step();
    sec_tick = 1'b0; stop = 1'b0; step();
    check("s_state", state, 2'b11);
    check("s_sec", sec_bcd, 8'h20);
    tick(2);
    pulse_pause();
    check("s_frozen_sec", sec_bcd, 8'h20);
    check("s_frozen_state", state, 2'b11);
    pulse_start();
    check("s_restart_state", state, 2'b01);
    check("s_restart_sec", sec_bcd, 8'h00);

    // Wrap / saturate at 99:59
    do_reset(); pulse_start();
    tick(5999);
    check("end_min", min_bcd, 8'h99);
    check("end_sec", sec_bcd, 8'h59);
    check("end_wrap0", wrap, 1'b0);
    sec_tick = 1'b1; step();
`ifdef GAME_TIMER_SATURATE_EN
    check("wrap_min", min_bcd, 8'h99);
    check("wrap_sec", sec_bcd, 8'h59);
`else
    check("wrap_min", min_bcd, 8'h00);
    check("wrap_sec", sec_bcd, 8'h00);
`endif
    check("wrap_pulse", wrap, 1'b1);
    check("wrap_state", state, 2'b01);
    sec_tick = 1'b0; step();
    check("wrap_clear", wrap, 1'b0);

    // Reset mid-run at 12:34
    do_reset(); pulse_start();
    tick(754);
    check("mid_min", min_bcd, 8'h12);
    check("mid_sec", sec_bcd, 8'h34);
    reset = 1'b1; sec_tick = 1'b1; step();
    reset = 1'b0; sec_tick = 1'b0;
    check("mid_rst_state", state, 2'b00);
    check("mid_rst_sec", sec_bcd, 8'h00);
    check("mid_rst_min", min_bcd, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 The module SHALL have parameter MIN_LAST, default 8'h99, meaning the last minute value in BCD before wrap/saturate.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port sec_tick, input, 1 bit: the 1 s pulse/level from the millisecond counter; only its rising edge counts.
REQ-005 The module SHALL have port start, input, 1 bit: single-cycle start/restart request.
REQ-006 The module SHALL have port pause, input, 1 bit: single-cycle pause/resume toggle.
REQ-007 The module SHALL have port stop, input, 1 bit: single-cycle game-over request.
REQ-008 The module SHALL have port sec_bcd, output, 8 bits: elapsed seconds, 2 BCD digits, 00-59.
REQ-009 The module SHALL have port min_bcd, output, 8 bits: elapsed minutes, 2 BCD digits, 00-MIN_LAST.
REQ-010 The module SHALL have port state, output, 2 bits: IDLE=00, RUN=01, PAUSE=10, OVER=11.
REQ-011 The module SHALL have port wrap, output, 1 bit: one-cycle pulse when the count passes MIN_LAST:59.

Function
REQ-012 The block SHALL detect the sec_tick edge with a registered copy tick_q that updates every cycle in all states; edge = sec_tick & ~tick_q.
REQ-013 From IDLE, start SHALL go to RUN and clear sec_bcd/min_bcd in the same cycle; pause and stop SHALL be ignored.
REQ-014 From RUN, stop SHALL go to OVER; else pause SHALL go to PAUSE; else an edge SHALL increment the count.
REQ-015 From PAUSE, stop SHALL go to OVER; else pause SHALL go to RUN; edges in PAUSE SHALL be discarded, not deferred.
REQ-016 From OVER, start SHALL go to RUN with counters cleared; the count SHALL otherwise hold frozen for display.
REQ-017 Priority within one cycle SHALL be stop > pause > tick edge; a tick edge coinciding with stop or pause SHALL be dropped.
REQ-018 An increment SHALL be BCD: sec low digit 9->0 carries; sec 59->00 carries to minutes; min low digit 9->0 carries.
REQ-019 An increment SHALL become visible on outputs the cycle after the edge is detected, giving 1-cycle latency.
REQ-020 Nibble values above 9 SHALL never appear on sec_bcd or min_bcd.
REQ-021 start while in RUN or PAUSE SHALL clear the count and enter or stay in RUN.

Reset
REQ-022 Reset SHALL set state=IDLE, sec_bcd=8'h00, min_bcd=8'h00, wrap=0, tick_q=1, so that a level already high at release is not counted.
REQ-023 Reset SHALL override all inputs in the same cycle, including mid-increment.

Configuration
REQ-024 With macro GAME_TIMER_SATURATE_EN defined, an edge at MIN_LAST:59 SHALL hold MIN_LAST:59, assert wrap once, and keep state RUN.
REQ-025 Without GAME_TIMER_SATURATE_EN, an edge at MIN_LAST:59 SHALL roll the count to 00:00 and pulse wrap for one cycle.

Structure
REQ-026 Package game_timer_pkg SHALL hold the state encoding typedef, BCD_NINE=4'h9, and SEC_LAST=8'h59.
REQ-027 Sub-module bcd_digit SHALL implement one mod-N BCD digit with enable, carry-in, and carry-out, instantiated four times.

Verification
REQ-028 Reset, start, then 61 tick edges SHALL yield min_bcd=8'h01 and sec_bcd=8'h01.
REQ-029 sec_tick held high for 5 cycles SHALL produce exactly one increment.
REQ-030 In RUN at 00:09, a pause pulse then 3 edges then a pause pulse then 1 edge SHALL yield 00:10.
REQ-031 stop and a tick edge in the same cycle at 00:20 SHALL yield OVER with the count frozen at 00:20; a following start SHALL yield RUN at 00:00.
REQ-032 Preloaded 99:59 plus one edge SHALL yield 00:00 with wrap=1 for one cycle, or 99:59 held when GAME_TIMER_SATURATE_EN is defined.
REQ-033 Reset asserted mid-run at 12:34 SHALL yield IDLE and 00:00 on the next cycle.
